// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline register (pipe_stage_reg).
//   PC_W_DEF / INSTR_W_DEF : default field widths
//   NOP_INSTR              : instruction word left behind by a zeroing flush
//   stage_state_e          : occupancy of a stage, derived from its slot valids
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned INSTR_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR   = 32'h0;

    // EMPTY: nothing held; FULL: main slot only; SKID: main and skid slots.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of a pipeline stage: a valid bit plus a data register.
// Control priority: flush_i > load_i > drop_i.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   flush_i    : clear valid; also zero the data when FLUSH_ZERO = 1
//   load_i     : capture data_i and set valid
//   drop_i     : clear valid, keep data (entry consumed downstream)
//   data_i     : data to capture
//   valid_o    : slot holds a live entry
//   data_o     : held data
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int unsigned W          = 8,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (FLUSH_ZERO) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset along with valid so the stage outputs
    // are defined zeros during and right after reset, not stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register (IF2ID, ID2EX, EX2MEM, MEM2WB) carrying PC,
// instruction and a sideband payload with a valid/ready handshake, flush and a
// 2-entry skid buffer (main slot drives the outputs, skid slot absorbs one
// entry of back-pressure). in_ready comes straight from a register, so there
// is no combinational path from out_ready to in_ready.
//
// Optional build macro PIPE_STAGE_PERF_EN adds saturating perf counters
// perf_stall_cnt (out_valid & !out_ready cycles) and perf_bubble_cnt
// (!out_valid cycles after reset release).
//
// Ports:
//   clk              stage clock, rising edge
//   rst              asynchronous active-low reset
//   flush            kill all held and incoming entries this cycle
//   in_valid/ready   upstream handshake
//   in_next_pc, in_instruction, in_payload   upstream entry
//   out_valid/ready  downstream handshake
//   out_next_pc, out_instruction, out_payload held entry
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W       = PC_W_DEF,
    parameter int unsigned INSTR_W    = INSTR_W_DEF,
    parameter int unsigned PAYLOAD_W  = 8,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_next_pc,
    input  logic [INSTR_W-1:0]   in_instruction,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_next_pc,
    output logic [INSTR_W-1:0]   out_instruction,
    output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt
`endif
);

    localparam int unsigned DATA_W = PC_W + INSTR_W + PAYLOAD_W;

    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] main_data, skid_data, main_load_data;
    logic              main_v, skid_v;
    logic              accept, drain;
    logic              main_load, main_from_skid, main_drop;
    logic              skid_load, skid_drop;
    logic              skid_v_next;
    logic              in_ready_q, in_ready_d;
    stage_state_e      state;

    assign in_data = {in_next_pc, in_instruction, in_payload};

    assign accept = in_valid & in_ready_q;
    assign drain  = main_v & out_ready;

    // Occupancy is fully described by the two valid bits.
    always_comb begin
        if (skid_v)      state = SKID;
        else if (main_v) state = FULL;
        else             state = EMPTY;
    end

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_drop      = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        unique case (state)
            EMPTY: begin
                main_load = accept;
            end
            FULL: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    // Downstream stalled: park the new entry, keep main stable.
                    skid_load = 1'b1;
                end else if (drain) begin
                    main_drop = 1'b1;
                end
            end
            SKID: begin
                // in_ready is low here, so only the skid-to-main move occurs.
                if (drain) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign main_load_data = main_from_skid ? skid_data : in_data;

    // in_ready for the next cycle is the complement of the next skid valid,
    // registered so it is visible at the port without any combinational logic.
    always_comb begin
        skid_v_next = skid_v;
        if (flush)          skid_v_next = 1'b0;
        else if (skid_load) skid_v_next = 1'b1;
        else if (skid_drop) skid_v_next = 1'b0;
        in_ready_d = ~skid_v_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    pipe_slot #(
        .W          (DATA_W),
        .FLUSH_ZERO (FLUSH_ZERO)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .data_i  (main_load_data),
        .valid_o (main_v),
        .data_o  (main_data)
    );

    pipe_slot #(
        .W          (DATA_W),
        .FLUSH_ZERO (FLUSH_ZERO)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .data_i  (in_data),
        .valid_o (skid_v),
        .data_o  (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign {out_next_pc, out_instruction, out_payload} = main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    // Saturating counters; flush does not touch them.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_v && !out_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
        if (!main_v && bubble_q != 32'hFFFF_FFFF) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign perf_stall_cnt  = stall_q;
    assign perf_bubble_cnt = bubble_q;
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. Entries accepted by the stage are
// pushed to a scoreboard queue and popped/compared when the stage drains them.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PAYLOAD_W = 8;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
        logic [PAYLOAD_W-1:0] pl;
    } entry_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PC_W-1:0]      in_next_pc = '0;
    logic [INSTR_W-1:0]   in_instruction = '0;
    logic [PAYLOAD_W-1:0] in_payload = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PC_W-1:0]      out_next_pc;
    logic [INSTR_W-1:0]   out_instruction;
    logic [PAYLOAD_W-1:0] out_payload;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]          perf_stall_cnt;
    logic [31:0]          perf_bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .PAYLOAD_W  (PAYLOAD_W),
        .FLUSH_ZERO (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_next_pc      (in_next_pc),
        .in_instruction  (in_instruction),
        .in_payload      (in_payload),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_next_pc     (out_next_pc),
        .out_instruction (out_instruction),
        .out_payload     (out_payload)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    entry_t sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     drained = 0;
    int     cov[3];
    bit     live = 1'b0;
    bit     hold_pend = 1'b0;
    entry_t held;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t cur_out();
        return {out_next_pc, out_instruction, out_payload};
    endfunction

    function automatic entry_t cur_in();
        return {in_next_pc, in_instruction, in_payload};
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        e.pc    = $urandom;
        e.instr = $urandom;
        e.pl    = PAYLOAD_W'($urandom);
        return e;
    endfunction

    task automatic drive(input bit v, input entry_t e);
        in_valid = v;
        {in_next_pc, in_instruction, in_payload} = e;
    endtask

    // One clock cycle: check the sampled state against the model, record the
    // handshakes that will fire at the coming edge, then advance past it.
    task automatic cycle();
        entry_t exp;
        if (live) begin
            check("out_valid_vs_model", out_valid, sb.size() > 0);
            check("in_ready_vs_model", in_ready, sb.size() < 2);
        end
        if (hold_pend) check("hold_stable", cur_out(), held);
        if (out_valid && out_ready) begin
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            check("out_data", cur_out(), exp);
            drained++;
        end
        if (in_valid && in_ready && !flush) sb.push_back(cur_in());
        if (flush) sb.delete();
        hold_pend = out_valid && !out_ready && !flush;
        held      = cur_out();
        cov[sb.size()]++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (sb.size() > 0) cycle();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Assert reset between edges, check the asynchronous effect, release it
    // between edges again and check in_ready rises on the first edge after.
    task automatic reset_seq();
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", cur_out(), '0);
        check("rst_in_ready", in_ready, 1'b0);
        sb.delete();
        live      = 1'b0;
        hold_pend = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_out_valid", out_valid, 1'b0);
        live = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        entry_t e0, e1, e2, e3;
        int d0;

        #1;
        reset_seq();

        // Single entry latency, then an 8-entry stream at full rate.
        e0 = '{pc: 32'h4, instr: 32'h0110_0093, pl: 8'h5a};
        out_ready = 1'b1;
        drained   = 0;
        drive(1'b1, e0);
        cycle();
        check("lat1_valid", out_valid, 1'b1);
        check("lat1_data", cur_out(), e0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, '{pc: 32'h4 + 32'(4 * i), instr: 32'h0110_0093 + 32'(i), pl: 8'(i)});
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("stream_count", drained, 8);

        // Back-pressure: FULL, SKID, third entry refused until room appears.
        e1 = rand_entry();
        e2 = rand_entry();
        e3 = rand_entry();
        d0 = drained;
        out_ready = 1'b0;
        drive(1'b1, e1);
        cycle();
        drive(1'b1, e2);
        cycle();
        check("skid_in_ready", in_ready, 1'b0);
        check("skid_holds_e1", cur_out(), e1);
        drive(1'b1, e3);
        cycle();
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (in_valid && in_ready) begin
                cycle();
                in_valid = 1'b0;
            end else begin
                cycle();
            end
        end
        drain_all();
        check("bp_count", drained - d0, 3);

        // Flush in SKID with an incoming entry.
        out_ready = 1'b0;
        drive(1'b1, rand_entry());
        cycle();
        drive(1'b1, rand_entry());
        cycle();
        drive(1'b1, rand_entry());
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_zero_instr", out_instruction, NOP_INSTR);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset mid-stream in SKID.
        out_ready = 1'b0;
        drive(1'b1, rand_entry());
        cycle();
        drive(1'b1, rand_entry());
        cycle();
        in_valid = 1'b0;
        check("pre_rst_skid", in_ready, 1'b0);
        reset_seq();
        d0 = drained;
        out_ready = 1'b1;
        drive(1'b1, rand_entry());
        cycle();
        drain_all();
        check("post_rst_count", drained - d0, 1);

        // Random handshake traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_entry());
            out_ready = $urandom_range(0, 2) != 0;
            cycle();
        end
        drain_all();
        check("cov_skid_seen", cov[2] > 0, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
        begin
            logic [31:0] s0, b0;
            out_ready = 1'b0;
            drive(1'b1, rand_entry());
            cycle();
            in_valid = 1'b0;
            s0 = perf_stall_cnt;
            for (int i = 0; i < 5; i++) cycle();
            check("perf_stall", perf_stall_cnt - s0, 32'd5);
            out_ready = 1'b1;
            cycle();
            b0 = perf_bubble_cnt;
            for (int i = 0; i < 3; i++) cycle();
            check("perf_bubble", perf_bubble_cnt - b0, 32'd3);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_reg
